// File: rtl/alu_md_unit.sv
// alu_md_unit: execute-stage ALU with MEM/WB operand forwarding and an
// iterative unsigned multiply/divide engine owning the HI/LO registers.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   valid_in, op_type          EX-stage instruction valid and 4-bit op code
//   reg_write_*_MEM/_WB        forwarding sources (enable, address)
//   read_register_*_EX         EX source register addresses
//   reg_read_data_*_EX         register-file operand values
//   extended_immi_EX           sign-extended immediate (LW/SW operand B)
//   alu_result_MEM             MEM-stage forward value
//   reg_write_data             WB-stage forward value
//   result                     combinational ALU result
//   hi, lo                     HI/LO registers
//   busy                       engine running (count != 0)
//   stall                      combinational hold request for IF/ID/EX
//   md_done                    one-cycle pulse after HI/LO update
module alu_md_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [3:0]         op_type,
    input  logic               reg_write_enable_MEM,
    input  logic               reg_write_enable_WB,
    input  logic [RADDR_W-1:0] reg_write_address_MEM,
    input  logic [RADDR_W-1:0] reg_write_address_WB,
    input  logic [RADDR_W-1:0] read_register_1_EX,
    input  logic [RADDR_W-1:0] read_register_2_EX,
    input  logic [WIDTH-1:0]   reg_read_data_1_EX,
    input  logic [WIDTH-1:0]   reg_read_data_2_EX,
    input  logic [WIDTH-1:0]   extended_immi_EX,
    input  logic [WIDTH-1:0]   alu_result_MEM,
    input  logic [WIDTH-1:0]   reg_write_data,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               stall,
    output logic               md_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_NOR   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_J     = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;
    localparam logic [3:0] OP_XOR   = 4'b1111;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] op_b;
    logic             is_md_op;
    logic             accept;

    logic [CNT_W-1:0] count;
    logic             is_div;
    logic [WIDTH-1:0] op_b_reg;   // multiplicand (MULTU) or divisor (DIVU)
    logic [WIDTH-1:0] work_hi;    // partial product high half / remainder
    logic [WIDTH-1:0] work_lo;    // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // Operand forwarding: MEM beats WB, register 0 is never forwarded.
    always_comb begin
        fwd_a = reg_read_data_1_EX;
        if (reg_write_enable_MEM && (reg_write_address_MEM == read_register_1_EX)
            && (read_register_1_EX != '0)) begin
            fwd_a = alu_result_MEM;
        end else if (reg_write_enable_WB && (reg_write_address_WB == read_register_1_EX)
                     && (read_register_1_EX != '0)) begin
            fwd_a = reg_write_data;
        end

        fwd_b = reg_read_data_2_EX;
        if (reg_write_enable_MEM && (reg_write_address_MEM == read_register_2_EX)
            && (read_register_2_EX != '0)) begin
            fwd_b = alu_result_MEM;
        end else if (reg_write_enable_WB && (reg_write_address_WB == read_register_2_EX)
                     && (read_register_2_EX != '0)) begin
            fwd_b = reg_write_data;
        end

        op_b = ((op_type == OP_LW) || (op_type == OP_SW)) ? extended_immi_EX : fwd_b;
    end

    // ALU result.
    always_comb begin
        result = '0;
        case (op_type)
            OP_ADD, OP_LW, OP_SW: result = fwd_a + op_b;
            OP_SUB:               result = fwd_a - op_b;
            OP_AND:               result = fwd_a & op_b;
            OP_OR:                result = fwd_a | op_b;
            OP_XOR:               result = fwd_a ^ op_b;
            OP_NOR:               result = ~(fwd_a | op_b);
            OP_SLT:               result = WIDTH'($signed(fwd_a) < $signed(op_b));
            OP_SLTU:              result = WIDTH'(fwd_a < op_b);
            OP_BEQ:               result = WIDTH'(fwd_a == op_b);
            OP_MFHI:              result = hi;
            OP_MFLO:              result = lo;
            OP_J, OP_MULTU, OP_DIVU: result = '0;
            default:              result = '0;
        endcase
    end

    assign is_md_op = (op_type == OP_MULTU) || (op_type == OP_DIVU);
    assign busy     = (count != '0);
    assign accept   = valid_in && is_md_op && !busy;
    assign stall    = valid_in && busy
                      && (is_md_op || (op_type == OP_MFHI) || (op_type == OP_MFLO));

    // One engine iteration: shift-add multiply or restoring divide step.
    always_comb begin
        logic [WIDTH-1:0] mul_add;
        logic [WIDTH:0]   mul_sum;
        logic [WIDTH:0]   div_shift;
        logic [WIDTH:0]   div_diff;

        mul_add   = work_lo[0] ? op_b_reg : '0;
        mul_sum   = {1'b0, work_hi} + {1'b0, mul_add};
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, op_b_reg};

        step_hi = work_hi;
        step_lo = work_lo;
        if (is_div) begin
            // Non-negative difference means the divisor fits: keep it, quotient bit 1.
            // A zero divisor always fits, giving all-ones quotient and remainder = A.
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
            end else begin
                step_hi = div_shift[WIDTH-1:0];
            end
            step_lo = {work_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

    // Engine state, HI/LO and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            is_div   <= 1'b0;
            op_b_reg <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            hi       <= '0;
            lo       <= '0;
            md_done  <= 1'b0;
        end else begin
            md_done <= (count == CNT_W'(1));
            if (accept) begin
                count    <= CNT_W'(WIDTH);
                is_div   <= (op_type == OP_DIVU);
                work_hi  <= '0;
                work_lo  <= (op_type == OP_DIVU) ? fwd_a : fwd_b;
                op_b_reg <= (op_type == OP_DIVU) ? fwd_b : fwd_a;
            end else if (busy) begin
                count   <= count - CNT_W'(1);
                work_hi <= step_hi;
                work_lo <= step_lo;
                if (count == CNT_W'(1)) begin
                    hi <= step_hi;
                    lo <= step_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: table of combinational vectors plus
// hand-written multiply/divide timing and reset-abort sequences.
module tb_alu_md_unit;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned RADDR_W = 5;

    localparam logic [3:0] OP_NOR   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_J     = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;
    localparam logic [3:0] OP_XOR   = 4'b1111;

    logic               clk = 1'b0;
    logic               reset;
    logic               valid_in;
    logic [3:0]         op_type;
    logic               reg_write_enable_MEM;
    logic               reg_write_enable_WB;
    logic [RADDR_W-1:0] reg_write_address_MEM;
    logic [RADDR_W-1:0] reg_write_address_WB;
    logic [RADDR_W-1:0] read_register_1_EX;
    logic [RADDR_W-1:0] read_register_2_EX;
    logic [WIDTH-1:0]   reg_read_data_1_EX;
    logic [WIDTH-1:0]   reg_read_data_2_EX;
    logic [WIDTH-1:0]   extended_immi_EX;
    logic [WIDTH-1:0]   alu_result_MEM;
    logic [WIDTH-1:0]   reg_write_data;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;
    logic               stall;
    logic               md_done;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_md_unit #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .valid_in              (valid_in),
        .op_type               (op_type),
        .reg_write_enable_MEM  (reg_write_enable_MEM),
        .reg_write_enable_WB   (reg_write_enable_WB),
        .reg_write_address_MEM (reg_write_address_MEM),
        .reg_write_address_WB  (reg_write_address_WB),
        .read_register_1_EX    (read_register_1_EX),
        .read_register_2_EX    (read_register_2_EX),
        .reg_read_data_1_EX    (reg_read_data_1_EX),
        .reg_read_data_2_EX    (reg_read_data_2_EX),
        .extended_immi_EX      (extended_immi_EX),
        .alu_result_MEM        (alu_result_MEM),
        .reg_write_data        (reg_write_data),
        .result                (result),
        .hi                    (hi),
        .lo                    (lo),
        .busy                  (busy),
        .stall                 (stall),
        .md_done               (md_done)
    );

    typedef struct {
        logic [3:0]         op;
        logic [RADDR_W-1:0] rr1;
        logic [WIDTH-1:0]   d1;
        logic [RADDR_W-1:0] rr2;
        logic [WIDTH-1:0]   d2;
        logic [WIDTH-1:0]   imm;
        logic               wem;
        logic [RADDR_W-1:0] wam;
        logic [WIDTH-1:0]   amem;
        logic               wew;
        logic [RADDR_W-1:0] waw;
        logic [WIDTH-1:0]   wbd;
        logic [WIDTH-1:0]   exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Plain operands, no forwarding hits.
    task automatic drive_plain(input logic [3:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
        valid_in              = 1'b1;
        op_type               = op;
        reg_write_enable_MEM  = 1'b0;
        reg_write_enable_WB   = 1'b0;
        reg_write_address_MEM = '0;
        reg_write_address_WB  = '0;
        read_register_1_EX    = 5'd1;
        read_register_2_EX    = 5'd2;
        reg_read_data_1_EX    = a;
        reg_read_data_2_EX    = b;
        extended_immi_EX      = '0;
        alu_result_MEM        = '0;
        reg_write_data        = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        valid_in              = 1'b1;
        op_type               = v.op;
        read_register_1_EX    = v.rr1;
        reg_read_data_1_EX    = v.d1;
        read_register_2_EX    = v.rr2;
        reg_read_data_2_EX    = v.d2;
        extended_immi_EX      = v.imm;
        reg_write_enable_MEM  = v.wem;
        reg_write_address_MEM = v.wam;
        alu_result_MEM        = v.amem;
        reg_write_enable_WB   = v.wew;
        reg_write_address_WB  = v.waw;
        reg_write_data        = v.wbd;
    endtask

    // Issue a MULTU/DIVU, an independent ADD, then MFLO until it stops stalling.
    task automatic run_md(input string name, input logic [3:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
        int n_stall;
        drive_plain(op, a, b);
        @(negedge clk);
        check({name, " issue stall"}, WIDTH'(stall), '0);
        check({name, " issue result"}, result, '0);
        next_cycle();
        drive_plain(OP_ADD, 32'd1, 32'd2);
        @(negedge clk);
        check({name, " busy after accept"}, WIDTH'(busy), 32'd1);
        check({name, " add no stall"}, WIDTH'(stall), '0);
        check({name, " add while busy"}, result, 32'd3);
        next_cycle();
        drive_plain(OP_MFLO, '0, '0);
        n_stall = 0;
        forever begin
            @(negedge clk);
            if (!stall || n_stall >= 100) break;
            n_stall++;
            next_cycle();
        end
        check({name, " stall cycles"}, WIDTH'(n_stall), 32'd31);
        check({name, " md_done"}, WIDTH'(md_done), 32'd1);
        check({name, " busy fallen"}, WIDTH'(busy), '0);
        check({name, " mflo result"}, result, exp_lo);
        check({name, " lo"}, lo, exp_lo);
        check({name, " hi"}, hi, exp_hi);
        next_cycle();
        drive_plain(OP_MFHI, '0, '0);
        @(negedge clk);
        check({name, " mfhi result"}, result, exp_hi);
        check({name, " md_done cleared"}, WIDTH'(md_done), '0);
        next_cycle();
    endtask

    initial begin
        int done_seen;
        // Columns: op, rr1, d1, rr2, d2, imm, wem, wam, amem, wew, waw, wbd, expected
        vecs.push_back('{OP_ADD,  5'd3, 32'd100, 5'd4, 32'd1, 32'd0, 1'b1, 5'd3, 32'd5, 1'b1, 5'd3, 32'd9, 32'd6});
        vecs.push_back('{OP_ADD,  5'd3, 32'd100, 5'd4, 32'd1, 32'd0, 1'b0, 5'd3, 32'd5, 1'b1, 5'd3, 32'd9, 32'd10});
        vecs.push_back('{OP_OR,   5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hF0, 32'd0});
        vecs.push_back('{OP_SLT,  5'd1, 32'hFFFFFFFF, 5'd2, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1});
        vecs.push_back('{OP_SLTU, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0});
        vecs.push_back('{OP_SLT,  5'd1, 32'hFFFFFFFE, 5'd2, 32'hFFFFFFFF, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1});
        vecs.push_back('{OP_SLTU, 5'd1, 32'd1, 5'd2, 32'hFFFFFFFF, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1});
        vecs.push_back('{OP_SLT,  5'd1, 32'd1, 5'd2, 32'hFFFFFFFF, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0});
        vecs.push_back('{OP_SUB,  5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hFFFFFFFE});
        vecs.push_back('{OP_AND,  5'd1, 32'h0000F0F0, 5'd2, 32'h0000FF00, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0000F000});
        vecs.push_back('{OP_XOR,  5'd1, 32'h0000F0F0, 5'd2, 32'h0000FF00, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h00000FF0});
        vecs.push_back('{OP_NOR,  5'd1, 32'h0F0F0000, 5'd2, 32'h00000F0F, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hF0F0F0F0});
        vecs.push_back('{OP_LW,   5'd1, 32'h100, 5'd2, 32'd999, 32'hFFFFFFFC, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h000000FC});
        vecs.push_back('{OP_SW,   5'd1, 32'd8, 5'd2, 32'd999, 32'd4, 1'b1, 5'd2, 32'd77, 1'b0, 5'd0, 32'd0, 32'd12});
        vecs.push_back('{OP_BEQ,  5'd1, 32'd5, 5'd2, 32'd5, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1});
        vecs.push_back('{OP_BEQ,  5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0});
        vecs.push_back('{OP_J,    5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0});
        vecs.push_back('{OP_SUB,  5'd1, 32'd50, 5'd7, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd20, 32'd30});
        vecs.push_back('{OP_SUB,  5'd6, 32'd1, 5'd8, 32'd1, 32'd0, 1'b1, 5'd8, 32'd3, 1'b1, 5'd6, 32'd40, 32'd37});
        vecs.push_back('{OP_ADD,  5'd1, 32'hFFFFFFFF, 5'd2, 32'd2, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1});
        vecs.push_back('{OP_MFHI, 5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0});
        vecs.push_back('{OP_MFLO, 5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0});

        reset = 1'b1;
        drive_plain(OP_ADD, '0, '0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", WIDTH'(busy), '0);
        check("reset stall", WIDTH'(stall), '0);
        check("reset md_done", WIDTH'(md_done), '0);
        check("reset hi", hi, '0);
        check("reset lo", lo, '0);
        check("reset result", result, '0);
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d result", i), result, vecs[i].exp);
            check($sformatf("vec%0d stall", i), WIDTH'(stall), '0);
            next_cycle();
        end

        run_md("multu 7*6", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);
        run_md("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1);
        run_md("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);

        // Abort an in-flight multiply with reset after 10 busy cycles.
        drive_plain(OP_MULTU, 32'd3, 32'd3);
        next_cycle();
        drive_plain(OP_ADD, '0, '0);
        valid_in = 1'b0;
        repeat (9) next_cycle();
        @(negedge clk);
        check("abort busy before reset", WIDTH'(busy), 32'd1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive_plain(OP_MFLO, '0, '0);
        @(negedge clk);
        check("abort busy", WIDTH'(busy), '0);
        check("abort stall", WIDTH'(stall), '0);
        check("abort hi", hi, '0);
        check("abort lo", lo, '0);
        check("abort mflo", result, '0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            @(negedge clk);
            if (md_done) done_seen++;
        end
        check("abort no md_done", WIDTH'(done_seen), '0);
        check("abort lo after wait", lo, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Execute-stage ALU for the pipelined MIPS core, generalised over data width.
- Keeps MEM/WB operand forwarding. Register 0 is never forwarded.
- Adds SLTU, XOR and NOR.
- Adds an iterative unsigned multiply/divide engine with HI/LO registers, a busy counter and a pipeline-stall handshake.

Parameters:
- WIDTH, 32: datapath width. Operands, result, HI and LO are all WIDTH bits.
- RADDR_W, 5: register-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  EX-stage instruction valid
- op_type  in  4  operation code
- reg_write_enable_MEM  in  1  MEM-stage write enable
- reg_write_enable_WB  in  1  WB-stage write enable
- reg_write_address_MEM  in  RADDR_W  MEM destination register
- reg_write_address_WB  in  RADDR_W  WB destination register
- read_register_1_EX  in  RADDR_W  source register A
- read_register_2_EX  in  RADDR_W  source register B
- reg_read_data_1_EX  in  WIDTH  register-file value A
- reg_read_data_2_EX  in  WIDTH  register-file value B
- extended_immi_EX  in  WIDTH  sign-extended immediate
- alu_result_MEM  in  WIDTH  MEM-stage forward value
- reg_write_data  in  WIDTH  WB-stage forward value
- result  out  WIDTH  combinational ALU result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  multiply/divide engine running
- stall  out  1  hold IF/ID/EX this cycle
- md_done  out  1  one-cycle pulse after HI/LO update

Behaviour:
- Op codes:
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 SLT (signed), 0110 LW, 0111 SW, 1000 BEQ, 1001 J
  - 1010 SLTU, 1011 MULTU, 1100 DIVU, 1101 MFHI, 1110 MFLO, 1111 XOR
  - 0000 NOR
- Forwarding, per operand:
  - MEM match has priority: enable set, address equal, address != 0 → use alu_result_MEM.
  - Otherwise WB match under the same rule → use reg_write_data.
  - Otherwise use the register-file value.
  - Operand B is replaced by extended_immi_EX for LW/SW.
- Result:
  - ADD/LW/SW: A+B, modulo 2^WIDTH.
  - SUB: A-B.
  - SLT: 1 if $signed(A) < $signed(B). SLTU: 1 if A < B unsigned.
  - BEQ: 1 if A==B.
  - MFHI: hi. MFLO: lo.
  - J, MULTU, DIVU: 0.
- Engine acceptance: at the edge where valid_in && op∈{MULTU,DIVU} && !busy.
  - Forwarded A and B are latched.
  - Count is loaded with WIDTH.
  - Engine starts the shift-add (MULTU) or restoring (DIVU) algorithm, one bit per cycle.
- Engine timing:
  - busy = (count != 0), so busy is high for exactly WIDTH cycles after the accept edge.
  - At the edge where count goes 1→0, HI/LO are written:
    - MULTU: {hi,lo} = A*B (2·WIDTH-bit product).
    - DIVU: lo = A/B, hi = A%B.
  - md_done is registered: it is high for the one cycle following that edge.
- Divide by zero: lo = all ones, hi = A. Timing is unchanged.
- stall is combinational: stall = valid_in && busy && op∈{MULTU,DIVU,MFHI,MFLO}.
  - While stalled, the stalled op is not accepted.
  - Other ops do not stall and execute normally while busy.
- MULTU/DIVU issue cycle itself: stall = 0; the pipeline proceeds.
- No-hazard latency: MFHI issued in the cycle after md_done-edge… precisely, the first non-stalled MFHI is in the cycle where busy has fallen. It reads the new hi combinationally in that same cycle.
- Reset:
  - hi, lo, count and md_done are cleared to 0, so busy=0 and stall=0.
  - An operation in flight is discarded: no md_done, no HI/LO update.
  - result depends only on inputs and hi/lo, so it is 0 for non-MF ops with zero inputs.
- valid_in=0: no acceptance and stall=0. result is still computed from the inputs.

Test Plan:
- Forwarding priority: MEM and WB both target r3, read_register_1_EX=3, alu_result_MEM=5, reg_write_data=9, ADD with B=1 → result=6. With MEM enable=0 → result=10.
- Register 0 guard: MEM writes r0 with alu_result_MEM=0xFF, read_register_1_EX=0, reg_read_data_1_EX=0, OR with B=0 → result=0.
- SLT vs SLTU: A=0xFFFFFFFF, B=1 → SLT=1, SLTU=0.
- MULTU then MFLO (WIDTH=32): A=7, B=6 accepted.
  - busy high for 32 cycles.
  - MFLO issued at cycle 2 → stall high for 31 cycles.
  - Then md_done=1, lo=42, hi=0, result=42.
  - A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=1.
- DIVU 100/7 → lo=14, hi=2 after 32 cycles. DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- Reset after 10 busy cycles of MULTU: busy=0, stall=0, hi=lo=0 next cycle. No md_done over the following 40 cycles.
